// File: rtl/mem_stage_pkg.sv
// Shared widths, funct3 encodings, FSM encodings and helpers for the memory stage.
package mem_stage_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned F3_W    = 3;
   localparam int unsigned STALL_W = 6;
   localparam int unsigned BE_W    = 4;

   // Load/store funct3 encodings
   localparam logic [F3_W-1:0] F3_B  = 3'b000;
   localparam logic [F3_W-1:0] F3_H  = 3'b001;
   localparam logic [F3_W-1:0] F3_W_ = 3'b010;
   localparam logic [F3_W-1:0] F3_BU = 3'b100;
   localparam logic [F3_W-1:0] F3_HU = 3'b101;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUSY = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   // Registered data-bus request payload
   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } dbus_pl_t;

   // Byte offset masked to the natural alignment of the access size
   function automatic logic [1:0] eff_off(input logic [F3_W-1:0] f3, input logic [1:0] off);
      logic [1:0] res;
      res = off;
      if (f3 == F3_H || f3 == F3_HU) res = {off[1], 1'b0};
      else if (f3 == F3_W_)          res = 2'b00;
      return res;
   endfunction

   // True when the access cannot be performed at this byte offset
   function automatic logic is_misaligned(input logic [F3_W-1:0] f3, input logic [1:0] off);
      return ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W_ && off != 2'b00);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding req/ack data bus between the memory stage and the data memory.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic              dbus_req;
   logic              dbus_we;
   logic [DATA_W-1:0] dbus_addr;
   logic [BE_W-1:0]   dbus_be;
   logic [DATA_W-1:0] dbus_wdata;
   logic              dbus_ack;
   logic [DATA_W-1:0] dbus_rdata;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      input  dbus_ack, dbus_rdata
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
      output dbus_ack, dbus_rdata
   );
endinterface

// File: rtl/mem_lane.sv
// Store byte-enable / lane replication and load byte/halfword extraction.
module mem_lane
   import mem_stage_pkg::*;
(
   input  logic [F3_W-1:0]   f3_i,
   input  logic [1:0]        off_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [BE_W-1:0]   be_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic [DATA_W-1:0] ldata_o
);

   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign off = eff_off(f3_i, off_i);

   // Byte enables and replicated store data by access size
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (f3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << off;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = 4'b0011 << off;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane selection from the read word
   always_comb begin
      ld_byte = rdata_i[7:0];
      case (off)
         2'd1:    ld_byte = rdata_i[15:8];
         2'd2:    ld_byte = rdata_i[23:16];
         2'd3:    ld_byte = rdata_i[31:24];
         default: ;
      endcase
      ld_half = off[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   // Sign/zero extension by funct3; unknown funct3 returns the raw word
   always_comb begin
      ldata_o = rdata_i;
      case (f3_i)
         F3_B:    ldata_o = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ldata_o = {24'd0, ld_byte};
         F3_H:    ldata_o = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ldata_o = {16'd0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one load/store over the data bus and
// stalls the pipeline until it completes. Optional MEM_MISALIGN_TRAP_EN turns
// misaligned halfword/word accesses into a bus-less trap with a misalign flag.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic [REG_W-1:0]   rd_i,
   input  logic [DATA_W-1:0]  alu_i,
   input  logic [DATA_W-1:0]  wdata_i,
   input  logic               mem_re_i,
   input  logic               mem_wr_i,
   input  logic [F3_W-1:0]    mem_f3_i,
   input  logic               wb_reg_wr_i,
   input  logic               wb_mem_sel_i,
   mem_stage_if.master        dbus,
   output logic               stall_req,
   output logic [REG_W-1:0]   rd,
   output logic [DATA_W-1:0]  alu,
   output logic               wb_reg_wr,
   output logic               wb_mem_sel,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic               misalign,
`endif
   output logic [DATA_W-1:0]  ldata
);

   logic [1:0]        state_q, state_d;
   logic              req_q, req_d;
   dbus_pl_t          pl_q, pl_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [BE_W-1:0]   lane_be;
   logic [DATA_W-1:0] lane_wdata;
   logic [DATA_W-1:0] lane_ldata;
   logic              access;
   logic              unused_stall;
`ifdef MEM_MISALIGN_TRAP_EN
   logic              misalign_q, misalign_d;
`endif

   assign access       = mem_re_i | mem_wr_i;
   assign unused_stall = ^{stall_i[STALL_W-1:4], stall_i[2:0]};

   mem_lane u_lane (
      .f3_i    (mem_f3_i),
      .off_i   (alu_i[1:0]),
      .wdata_i (wdata_i),
      .rdata_i (rdata_q),
      .be_o    (lane_be),
      .wdata_o (lane_wdata),
      .ldata_o (lane_ldata)
   );

   // Next-state and bus-request logic
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      pl_d    = pl_q;
      rdata_d = rdata_q;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (access) begin
`ifdef MEM_MISALIGN_TRAP_EN
               if (is_misaligned(mem_f3_i, alu_i[1:0])) begin
                  state_d    = ST_DONE;
                  misalign_d = 1'b1;
               end else begin
`endif
                  state_d     = ST_BUSY;
                  req_d       = 1'b1;
                  pl_d.we     = mem_wr_i;
                  pl_d.addr   = {alu_i[DATA_W-1:2], 2'b00};
                  pl_d.be     = lane_be;
                  pl_d.wdata  = lane_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
               end
`endif
            end
         end
         ST_BUSY: begin
            if (dbus.dbus_ack) begin
               state_d = ST_DONE;
               req_d   = 1'b0;
               rdata_d = dbus.dbus_rdata;
            end
         end
         ST_DONE: begin
            if (!stall_i[3]) begin
               state_d = ST_IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
               misalign_d = 1'b0;
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and bus registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         pl_q    <= '0;
         rdata_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pl_q    <= pl_d;
         rdata_q <= rdata_d;
`ifdef MEM_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign dbus.dbus_req   = req_q;
   assign dbus.dbus_we    = pl_q.we;
   assign dbus.dbus_addr  = pl_q.addr;
   assign dbus.dbus_be    = pl_q.be;
   assign dbus.dbus_wdata = pl_q.wdata;

   assign stall_req  = access && (state_q != ST_DONE);
   assign rd         = rd_i;
   assign alu        = alu_i;
   assign wb_mem_sel = wb_mem_sel_i;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign  = misalign_q;
   assign wb_reg_wr = wb_reg_wr_i & ~misalign_q;
   assign ldata     = (mem_re_i && !misalign_q) ? lane_ldata : '0;
`else
   assign wb_reg_wr = wb_reg_wr_i;
   assign ldata     = mem_re_i ? lane_ldata : '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: vector table of single accesses plus
// hand-written reset, stall-hold, back-to-back and misalign sequences.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [STALL_W-1:0] stall_i;
   logic [REG_W-1:0]   rd_i;
   logic [DATA_W-1:0]  alu_i, wdata_i;
   logic               mem_re_i, mem_wr_i;
   logic [F3_W-1:0]    mem_f3_i;
   logic               wb_reg_wr_i, wb_mem_sel_i;
   logic               stall_req;
   logic [REG_W-1:0]   rd;
   logic [DATA_W-1:0]  alu, ldata;
   logic               wb_reg_wr, wb_mem_sel;
`ifdef MEM_MISALIGN_TRAP_EN
   logic               misalign;
`endif

   int tests = 0;
   int fails = 0;

   mem_stage_if bus ();

   mem_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .rd_i         (rd_i),
      .alu_i        (alu_i),
      .wdata_i      (wdata_i),
      .mem_re_i     (mem_re_i),
      .mem_wr_i     (mem_wr_i),
      .mem_f3_i     (mem_f3_i),
      .wb_reg_wr_i  (wb_reg_wr_i),
      .wb_mem_sel_i (wb_mem_sel_i),
      .dbus         (bus),
      .stall_req    (stall_req),
      .rd           (rd),
      .alu          (alu),
      .wb_reg_wr    (wb_reg_wr),
      .wb_mem_sel   (wb_mem_sel),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign     (misalign),
`endif
      .ldata        (ldata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      bit          st;
      logic [31:0] alu;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
      bit          stray;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_ldata;
      int          e_stalls;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string n, logic [2:0] f3, bit st, logic [31:0] a, logic [31:0] wd,
                               logic [31:0] rdv, int dly, bit stray, logic [31:0] ea, logic [3:0] ebe,
                               logic [31:0] ewd, logic [31:0] eld, int est);
      vec_t v;
      v.name = n; v.f3 = f3; v.st = st; v.alu = a; v.wdata = wd; v.rdata = rdv;
      v.delay = dly; v.stray = stray; v.e_addr = ea; v.e_be = ebe; v.e_wdata = ewd;
      v.e_ldata = eld; v.e_stalls = est;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      mem_re_i = 1'b0; mem_wr_i = 1'b0; mem_f3_i = 3'b000; alu_i = '0; wdata_i = '0;
      rd_i = '0; wb_reg_wr_i = 1'b0; wb_mem_sel_i = 1'b0;
      bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h5A5A5A5A;
   endtask

   // One complete access with a simple slave acking in BUSY cycle v.delay
   task automatic run_vec(input vec_t v);
      int          stalls = 0;
      int          busy = 0;
      bit          done = 1'b0;
      bit          stable = 1'b1;
      logic [31:0] s_addr = '0, s_wd = '0;
      logic [3:0]  s_be = '0;
      logic        s_we = 1'b0;
      mem_re_i = !v.st; mem_wr_i = v.st; mem_f3_i = v.f3; alu_i = v.alu; wdata_i = v.wdata;
      rd_i = 5'd9; wb_reg_wr_i = !v.st; wb_mem_sel_i = !v.st;
      #1;
      chk({v.name, " alu"}, alu, v.alu);
      chk({v.name, " rd"}, 32'(rd), 32'd9);
      for (int c = 0; c < 64; c++) begin
         if (stall_req) stalls++;
         else if (c > 0) begin done = 1'b1; break; end
         bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h5A5A5A5A;
         if (bus.dbus_req) begin
            if (busy == 0) begin
               s_addr = bus.dbus_addr; s_be = bus.dbus_be; s_wd = bus.dbus_wdata; s_we = bus.dbus_we;
            end else if (s_addr !== bus.dbus_addr || s_be !== bus.dbus_be ||
                         s_wd !== bus.dbus_wdata || s_we !== bus.dbus_we) begin
               stable = 1'b0;
            end
            if (busy == v.delay - 1) begin bus.dbus_ack = 1'b1; bus.dbus_rdata = v.rdata; end
            busy++;
         end else if (c == 0 && v.stray) begin
            bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hBADBAD00;
         end
         @(negedge clk);
      end
      chk({v.name, " completed"}, 32'(done), 32'd1);
      chk({v.name, " stalls"}, 32'(stalls), 32'(v.e_stalls));
      chk({v.name, " addr"}, s_addr, v.e_addr);
      chk({v.name, " be"}, 32'(s_be), 32'(v.e_be));
      chk({v.name, " wdata"}, s_wd, v.e_wdata);
      chk({v.name, " we"}, 32'(s_we), 32'(v.st));
      chk({v.name, " stable"}, 32'(stable), 32'd1);
      chk({v.name, " ldata"}, ldata, v.e_ldata);
      chk({v.name, " req_clear"}, 32'(bus.dbus_req), 32'd0);
      clear_inputs();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      stall_i = '0;
      clear_inputs();

      vecs.push_back(mk("LW",   3'b010, 0, 32'h100, 0, 32'hDEADBEEF, 1, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 2));
      vecs.push_back(mk("LB",   3'b000, 0, 32'h103, 0, 32'h80FF0000, 1, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 2));
      vecs.push_back(mk("LBU",  3'b100, 0, 32'h103, 0, 32'h80FF0000, 1, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080, 2));
      vecs.push_back(mk("LH",   3'b001, 0, 32'h102, 0, 32'h80FF0000, 1, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFF80FF, 2));
      vecs.push_back(mk("LHU",  3'b101, 0, 32'h100, 0, 32'h1234F00D, 1, 0, 32'h100, 4'b0011, 32'h0, 32'h0000F00D, 2));
      vecs.push_back(mk("LBpos",3'b000, 0, 32'h101, 0, 32'h00007F00, 1, 0, 32'h100, 4'b0010, 32'h0, 32'h0000007F, 2));
      vecs.push_back(mk("LRAW", 3'b011, 0, 32'h104, 0, 32'h89ABCDEF, 1, 0, 32'h104, 4'b1111, 32'h0, 32'h89ABCDEF, 2));
      vecs.push_back(mk("SH",   3'b001, 1, 32'h22, 32'h1234ABCD, 0, 1, 0, 32'h20, 4'b1100, 32'hABCDABCD, 32'h0, 2));
      vecs.push_back(mk("SB",   3'b000, 1, 32'h41, 32'h000000A5, 0, 1, 0, 32'h40, 4'b0010, 32'hA5A5A5A5, 32'h0, 2));
      vecs.push_back(mk("SW",   3'b010, 1, 32'h80, 32'hCAFEF00D, 0, 1, 0, 32'h80, 4'b1111, 32'hCAFEF00D, 32'h0, 2));
      vecs.push_back(mk("SLOW", 3'b010, 0, 32'h200, 0, 32'h01234567, 4, 1, 32'h200, 4'b1111, 32'h0, 32'h01234567, 5));
`ifndef MEM_MISALIGN_TRAP_EN
      vecs.push_back(mk("LHmask",3'b001, 0, 32'h103, 0, 32'hBEEF8001, 1, 0, 32'h100, 4'b1100, 32'h0, 32'hFFFFBEEF, 2));
      vecs.push_back(mk("SWmask",3'b010, 1, 32'h106, 32'h13579BDF, 0, 2, 0, 32'h104, 4'b1111, 32'h13579BDF, 32'h0, 3));
`endif

      // Reset state
      mem_re_i = 1'b1; mem_f3_i = 3'b010;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req", 32'(bus.dbus_req), 32'd0);
      chk("rst we", 32'(bus.dbus_we), 32'd0);
      chk("rst be", 32'(bus.dbus_be), 32'd0);
      chk("rst addr", bus.dbus_addr, 32'd0);
      chk("rst wdata", bus.dbus_wdata, 32'd0);
      chk("rst ldata", ldata, 32'd0);
      mem_re_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("idle nostall", 32'(stall_req), 32'd0);

      // Stray ack with no access pending
      bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hBADBAD00;
      @(negedge clk);
      bus.dbus_ack = 1'b0;
      chk("stray req", 32'(bus.dbus_req), 32'd0);
      chk("stray stall", 32'(stall_req), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // DONE held by stall_i[3]: no re-issue, result held
      mem_re_i = 1'b1; mem_f3_i = 3'b010; alu_i = 32'h300;
      @(negedge clk);
      bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h11112222;
      @(negedge clk);
      bus.dbus_ack = 1'b0; bus.dbus_rdata = 32'h5A5A5A5A;
      stall_i[3] = 1'b1;
      chk("hold done stall", 32'(stall_req), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("hold stall", 32'(stall_req), 32'd0);
         chk("hold noreq", 32'(bus.dbus_req), 32'd0);
         chk("hold ldata", ldata, 32'h11112222);
      end
      stall_i[3] = 1'b0;
      @(negedge clk);
      chk("hold release idle", 32'(stall_req), 32'd1);
      mem_re_i = 1'b0;
      @(negedge clk);

      // Back-to-back: load then store, one IDLE cycle between
      mem_re_i = 1'b1; mem_f3_i = 3'b010; alu_i = 32'h310;
      @(negedge clk);
      bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'h33334444;
      @(negedge clk);
      bus.dbus_ack = 1'b0;
      chk("b2b ld done", ldata, 32'h33334444);
      @(posedge clk); #1;
      mem_re_i = 1'b0; mem_wr_i = 1'b1; alu_i = 32'h314; wdata_i = 32'h0BADF00D;
      @(negedge clk);
      chk("b2b idle stall", 32'(stall_req), 32'd1);
      chk("b2b idle noreq", 32'(bus.dbus_req), 32'd0);
      @(negedge clk);
      chk("b2b st req", 32'(bus.dbus_req), 32'd1);
      chk("b2b st we", 32'(bus.dbus_we), 32'd1);
      chk("b2b st addr", bus.dbus_addr, 32'h314);
      bus.dbus_ack = 1'b1;
      @(negedge clk);
      bus.dbus_ack = 1'b0;
      chk("b2b st done", 32'(stall_req), 32'd0);
      clear_inputs();
      @(negedge clk);

      // Reset while BUSY, then a late ack must not complete anything
      mem_re_i = 1'b1; mem_f3_i = 3'b010; alu_i = 32'h400;
      @(negedge clk);
      chk("rstbusy req", 32'(bus.dbus_req), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("rstbusy req drop", 32'(bus.dbus_req), 32'd0);
      chk("rstbusy idle stall", 32'(stall_req), 32'd1);
      rst = 1'b1; mem_re_i = 1'b0; bus.dbus_ack = 1'b1; bus.dbus_rdata = 32'hBADBAD00;
      @(negedge clk);
      bus.dbus_ack = 1'b0;
      chk("late ack req", 32'(bus.dbus_req), 32'd0);
      mem_re_i = 1'b1;
      #1;
      chk("late ack not done", 32'(stall_req), 32'd1);
      mem_re_i = 1'b0;
      @(negedge clk);

`ifdef MEM_MISALIGN_TRAP_EN
      // Misaligned LW traps without a bus request
      mem_re_i = 1'b1; mem_f3_i = 3'b010; alu_i = 32'h102; wb_reg_wr_i = 1'b1;
      #1;
      chk("mis c0 stall", 32'(stall_req), 32'd1);
      chk("mis c0 flag", 32'(misalign), 32'd0);
      @(negedge clk);
      chk("mis req", 32'(bus.dbus_req), 32'd0);
      chk("mis stall", 32'(stall_req), 32'd0);
      chk("mis flag", 32'(misalign), 32'd1);
      chk("mis wb_reg_wr", 32'(wb_reg_wr), 32'd0);
      chk("mis ldata", ldata, 32'd0);
      mem_re_i = 1'b0;
      @(negedge clk);
      chk("mis flag clear", 32'(misalign), 32'd0);
      chk("mis wb_reg_wr back", 32'(wb_reg_wr), 32'd1);
      wb_reg_wr_i = 1'b0;
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
